// File: rtl/mem_stage_if.sv
// Memory-stage bus bundle: execute-side inputs plus write-back and forwarding outputs.
// The master drives the execute side; the slave (mem_stage) drives the results.
interface mem_stage_if #(
    parameter int unsigned EX_TO_MEM_WD = 76,
    parameter int unsigned MEM_TO_WB_WD = 70,
    parameter int unsigned MEM_TO_RF_WD = 38
);
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [4:0]              ex_load_bus;
    logic [3:0]              data_ram_sel;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus;

    modport master (
        output ex_to_mem_bus,
        output ex_load_bus,
        output data_ram_sel,
        output data_sram_rdata,
        input  mem_to_wb_bus,
        input  mem_to_rf_bus
    );

    modport slave (
        input  ex_to_mem_bus,
        input  ex_load_bus,
        input  data_ram_sel,
        input  data_sram_rdata,
        output mem_to_wb_bus,
        output mem_to_rf_bus
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: stall-aware pipeline register, SRAM response hold buffer,
// load alignment/extension, and write-back / forwarding bus generation.
module mem_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] stall,
    mem_stage_if.slave bus
);
    localparam int unsigned EX_TO_MEM_WD = 76;
    localparam int unsigned MEM_TO_WB_WD = 70;
    localparam int unsigned MEM_TO_RF_WD = 38;

    logic [EX_TO_MEM_WD-1:0] r_bus;
    logic [4:0]              r_load;
    logic [3:0]              r_sel;
    logic                    r_first;
    logic [31:0]             r_rdata_hold;

    logic [31:0]             w_pc;
    logic                    w_sel_rf_res;
    logic                    w_rf_we;
    logic [4:0]              w_rf_waddr;
    logic [31:0]             w_ex_result;
    logic [31:0]             w_rdata_eff;
    logic [7:0]              w_byte;
    logic                    w_byte_ok;
    logic [15:0]             w_half;
    logic                    w_half_ok;
    logic [31:0]             w_load_data;
    logic [31:0]             w_rf_wdata;
    logic [MEM_TO_WB_WD-1:0] w_wb;
    logic [MEM_TO_RF_WD-1:0] w_rf;
    logic                    w_unused;

    // Pipeline register: reset, bubble when only this stage stalls, load when running, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus   <= '0;
            r_load  <= '0;
            r_sel   <= '0;
            r_first <= 1'b0;
        end else if (stall[3] && !stall[4]) begin
            r_bus   <= '0;
            r_load  <= '0;
            r_sel   <= '0;
            r_first <= 1'b0;
        end else if (!stall[3]) begin
            r_bus   <= bus.ex_to_mem_bus;
            r_load  <= bus.ex_load_bus;
            r_sel   <= bus.data_ram_sel;
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
        end
    end

    // The SRAM response is only valid in the first cycle; keep it for any stalled cycles after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_hold <= '0;
        end else if (r_first) begin
            r_rdata_hold <= bus.data_sram_rdata;
        end
    end

    assign w_pc         = r_bus[75:44];
    assign w_sel_rf_res = r_bus[38];
    assign w_rf_we      = r_bus[37];
    assign w_rf_waddr   = r_bus[36:32];
    assign w_ex_result  = r_bus[31:0];
    assign w_rdata_eff  = r_first ? bus.data_sram_rdata : r_rdata_hold;

    always_comb begin
        w_byte    = 8'h00;
        w_byte_ok = 1'b1;
        w_half    = 16'h0000;
        w_half_ok = 1'b1;
        case (r_sel)
            4'b0001: w_byte = w_rdata_eff[7:0];
            4'b0010: w_byte = w_rdata_eff[15:8];
            4'b0100: w_byte = w_rdata_eff[23:16];
            4'b1000: w_byte = w_rdata_eff[31:24];
            default: w_byte_ok = 1'b0;
        endcase
        case (r_sel)
            4'b0011: w_half = w_rdata_eff[15:0];
            4'b1100: w_half = w_rdata_eff[31:16];
            default: w_half_ok = 1'b0;
        endcase
    end

    // r_load = {lb, lbu, lh, lhu, lw}
    always_comb begin
        w_load_data = 32'h0;
        if (r_load[4]) begin
            if (w_byte_ok) w_load_data = {{24{w_byte[7]}}, w_byte};
        end else if (r_load[3]) begin
            if (w_byte_ok) w_load_data = {24'h0, w_byte};
        end else if (r_load[2]) begin
            if (w_half_ok) w_load_data = {{16{w_half[15]}}, w_half};
        end else if (r_load[1]) begin
            if (w_half_ok) w_load_data = {16'h0, w_half};
        end else if (r_load[0]) begin
            w_load_data = w_rdata_eff;
        end
    end

    assign w_rf_wdata = w_sel_rf_res ? w_load_data : w_ex_result;
    assign w_rf       = {w_rf_we, w_rf_waddr, w_rf_wdata};
    assign w_wb       = {w_pc, w_rf};

    assign bus.mem_to_wb_bus = w_wb;
    assign bus.mem_to_rf_bus = w_rf;

    // Store controls and other stages' stall bits are not used here.
    assign w_unused = ^{stall[5], stall[2:0], r_bus[43:39]};
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage using an expected-result scoreboard queue.
module tb_mem_stage;
    localparam int unsigned EX_WD = 76;
    localparam int unsigned WB_WD = 70;
    localparam int unsigned RF_WD = 38;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stall;

    mem_stage_if #(.EX_TO_MEM_WD(EX_WD), .MEM_TO_WB_WD(WB_WD), .MEM_TO_RF_WD(RF_WD)) bus_if ();

    mem_stage dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [WB_WD-1:0] sb_q[$];
    logic [WB_WD-1:0] exp_wb;

    localparam logic [4:0] LD_NONE = 5'b00000;
    localparam logic [4:0] LD_LB   = 5'b10000;
    localparam logic [4:0] LD_LBU  = 5'b01000;
    localparam logic [4:0] LD_LH   = 5'b00100;
    localparam logic [4:0] LD_LHU  = 5'b00010;
    localparam logic [4:0] LD_LW   = 5'b00001;

    function automatic logic [31:0] model_load(input logic [4:0] ld, input logic [3:0] sel,
                                               input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic        bv;
        logic        hv;
        bv = 1'b1;
        hv = 1'b1;
        b  = 8'h00;
        h  = 16'h0000;
        case (sel)
            4'b0001: b = d[7:0];
            4'b0010: b = d[15:8];
            4'b0100: b = d[23:16];
            4'b1000: b = d[31:24];
            default: bv = 1'b0;
        endcase
        case (sel)
            4'b0011: h = d[15:0];
            4'b1100: h = d[31:16];
            default: hv = 1'b0;
        endcase
        case (ld)
            LD_LB:   return bv ? {{24{b[7]}}, b} : 32'h0;
            LD_LBU:  return bv ? {24'h0, b} : 32'h0;
            LD_LH:   return hv ? {{16{h[15]}}, h} : 32'h0;
            LD_LHU:  return hv ? {16'h0, h} : 32'h0;
            LD_LW:   return d;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive_ex(input logic [31:0] pc, input logic srr, input logic we,
                            input logic [4:0] waddr, input logic [31:0] exr,
                            input logic [4:0] ld, input logic [3:0] sel);
        bus_if.ex_to_mem_bus = {pc, 1'b1, 4'h0, srr, we, waddr, exr};
        bus_if.ex_load_bus   = ld;
        bus_if.data_ram_sel  = sel;
    endtask

    // Latch one instruction and present its SRAM response; ends 2 time units after the edge.
    task automatic issue(input logic [31:0] pc, input logic srr, input logic we,
                         input logic [4:0] waddr, input logic [31:0] exr, input logic [4:0] ld,
                         input logic [3:0] sel, input logic [31:0] rdata,
                         input logic [31:0] exp_wdata);
        @(negedge clk);
        stall = 6'b0;
        drive_ex(pc, srr, we, waddr, exr, ld, sel);
        sb_q.push_back({pc, we, waddr, exp_wdata});
        @(posedge clk);
        #1;
        bus_if.data_sram_rdata = rdata;
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        stall = 6'($urandom);
        bus_if.ex_to_mem_bus   = {$urandom, $urandom, 12'($urandom)};
        bus_if.ex_load_bus     = 5'($urandom);
        bus_if.data_ram_sel    = 4'($urandom);
        bus_if.data_sram_rdata = $urandom;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            bus_if.data_sram_rdata = $urandom;
            checks++;
            if (bus_if.mem_to_wb_bus !== '0 || bus_if.mem_to_rf_bus !== '0) begin
                errors++;
                $display("FAIL reset_%0d: wb=%h rf=%h expected 0", i, bus_if.mem_to_wb_bus,
                         bus_if.mem_to_rf_bus);
            end
        end
        @(negedge clk);
        rst   = 1'b0;
        stall = 6'b0;
        #1;
        checks++;
        if (bus_if.mem_to_wb_bus !== '0 || bus_if.mem_to_rf_bus !== '0) begin
            errors++;
            $display("FAIL reset_release: wb=%h rf=%h expected 0", bus_if.mem_to_wb_bus,
                     bus_if.mem_to_rf_bus);
        end
    endtask

    task automatic test_lw();
        issue(32'hBFC0_0100, 1'b1, 1'b1, 5'd5, 32'h1000, LD_LW, 4'b1111, 32'hDEAD_BEEF,
              32'hDEAD_BEEF);
        exp_wb = sb_q.pop_front();
        checks++;
        if (bus_if.mem_to_wb_bus !== exp_wb || bus_if.mem_to_rf_bus !== exp_wb[37:0]) begin
            errors++;
            $display("FAIL lw_basic: wb=%h rf=%h expected wb=%h", bus_if.mem_to_wb_bus,
                     bus_if.mem_to_rf_bus, exp_wb);
        end
    endtask

    task automatic test_lanes();
        logic [4:0]  ld_t [5];
        logic [3:0]  sel_t[5];
        logic [31:0] exp_t[5];
        ld_t  = '{LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LB};
        sel_t = '{4'b0100, 4'b0100, 4'b1100, 4'b0011, 4'b0011};
        exp_t = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0080, 32'h0000_FF00, 32'h0};
        for (int i = 0; i < 5; i++) begin
            issue(32'hBFC0_0200 + 32'(i * 4), 1'b1, 1'b1, 5'(8 + i), 32'h2002, ld_t[i],
                  sel_t[i], 32'h0080_FF00, exp_t[i]);
            exp_wb = sb_q.pop_front();
            checks++;
            if (bus_if.mem_to_wb_bus !== exp_wb || bus_if.mem_to_rf_bus !== exp_wb[37:0]) begin
                errors++;
                $display("FAIL lane_%0d: wb=%h rf=%h expected wb=%h", i, bus_if.mem_to_wb_bus,
                         bus_if.mem_to_rf_bus, exp_wb);
            end
        end
    endtask

    task automatic test_hold();
        issue(32'hBFC0_0300, 1'b1, 1'b1, 5'd9, 32'h3000, LD_LW, 4'b1111, 32'h1234_5678,
              32'h1234_5678);
        exp_wb = sb_q.pop_front();
        checks++;
        if (bus_if.mem_to_wb_bus !== exp_wb) begin
            errors++;
            $display("FAIL hold_first: wb=%h expected %h", bus_if.mem_to_wb_bus, exp_wb);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 6'b011000;
            drive_ex(32'h0BAD_0000, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, LD_NONE, 4'b0);
            sb_q.push_back(exp_wb);
            @(posedge clk);
            #1;
            bus_if.data_sram_rdata = 32'hAAAA_AAAA;
            #1;
            exp_wb = sb_q.pop_front();
            checks++;
            if (bus_if.mem_to_wb_bus !== exp_wb || bus_if.mem_to_rf_bus !== exp_wb[37:0]) begin
                errors++;
                $display("FAIL hold_stall_%0d: wb=%h expected %h", i, bus_if.mem_to_wb_bus,
                         exp_wb);
            end
        end
        @(negedge clk);
        stall = 6'b0;
    endtask

    task automatic test_bubble();
        issue(32'hBFC0_0400, 1'b0, 1'b1, 5'd3, 32'h7777, LD_NONE, 4'b0, 32'h0, 32'h7777);
        exp_wb = sb_q.pop_front();
        checks++;
        if (bus_if.mem_to_wb_bus !== exp_wb) begin
            errors++;
            $display("FAIL bubble_pre: wb=%h expected %h", bus_if.mem_to_wb_bus, exp_wb);
        end
        @(negedge clk);
        stall = 6'b001000;
        drive_ex(32'hBFC0_0404, 1'b1, 1'b1, 5'd4, 32'h8888, LD_LW, 4'b1111);
        sb_q.push_back('0);
        @(posedge clk);
        #1;
        bus_if.data_sram_rdata = 32'hCAFE_F00D;
        #1;
        exp_wb = sb_q.pop_front();
        checks++;
        if (bus_if.mem_to_wb_bus !== exp_wb || bus_if.mem_to_rf_bus !== exp_wb[37:0]) begin
            errors++;
            $display("FAIL bubble: wb=%h rf=%h expected 0", bus_if.mem_to_wb_bus,
                     bus_if.mem_to_rf_bus);
        end
        @(negedge clk);
        stall = 6'b0;
    endtask

    task automatic test_alu_and_reset_hold();
        issue(32'hBFC0_0500, 1'b0, 1'b1, 5'd7, 32'h0000_0042, LD_LW, 4'b1111, $urandom,
              32'h0000_0042);
        exp_wb = sb_q.pop_front();
        checks++;
        if (bus_if.mem_to_wb_bus !== exp_wb || bus_if.mem_to_rf_bus !== exp_wb[37:0]) begin
            errors++;
            $display("FAIL alu_path: wb=%h expected %h", bus_if.mem_to_wb_bus, exp_wb);
        end
        issue(32'hBFC0_0504, 1'b1, 1'b1, 5'd12, 32'h4000, LD_LW, 4'b1111, 32'h55AA_55AA,
              32'h55AA_55AA);
        exp_wb = sb_q.pop_front();
        checks++;
        if (bus_if.mem_to_wb_bus !== exp_wb) begin
            errors++;
            $display("FAIL rst_hold_pre: wb=%h expected %h", bus_if.mem_to_wb_bus, exp_wb);
        end
        @(negedge clk);
        stall = 6'b011000;
        @(posedge clk);
        #1;
        bus_if.data_sram_rdata = 32'h0F0F_0F0F;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (bus_if.mem_to_wb_bus !== '0 || bus_if.mem_to_rf_bus !== '0) begin
            errors++;
            $display("FAIL rst_mid_hold: wb=%h rf=%h expected 0", bus_if.mem_to_wb_bus,
                     bus_if.mem_to_rf_bus);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus_if.data_sram_rdata = 32'h1357_9BDF;
        #1;
        checks++;
        if (bus_if.mem_to_wb_bus !== '0 || bus_if.mem_to_rf_bus !== '0) begin
            errors++;
            $display("FAIL rst_hold_cleared: wb=%h rf=%h expected 0", bus_if.mem_to_wb_bus,
                     bus_if.mem_to_rf_bus);
        end
        @(negedge clk);
        stall = 6'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ld_opts [6];
        logic [3:0]  sel_opts[8];
        logic [4:0]  ld;
        logic [3:0]  sel;
        logic        srr;
        logic [31:0] exr;
        logic [31:0] rd;
        ld_opts  = '{LD_NONE, LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW};
        sel_opts = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0110};
        for (int i = 0; i < 24; i++) begin
            ld  = ld_opts[$urandom_range(0, 5)];
            sel = sel_opts[$urandom_range(0, 7)];
            srr = 1'($urandom);
            exr = $urandom;
            rd  = $urandom;
            issue($urandom, srr, 1'($urandom), 5'($urandom), exr, ld, sel, rd,
                  srr ? model_load(ld, sel, rd) : exr);
            exp_wb = sb_q.pop_front();
            checks++;
            if (bus_if.mem_to_wb_bus !== exp_wb || bus_if.mem_to_rf_bus !== exp_wb[37:0]) begin
                errors++;
                $display("FAIL b2b_%0d: wb=%h rf=%h expected wb=%h", i, bus_if.mem_to_wb_bus,
                         bus_if.mem_to_rf_bus, exp_wb);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_lanes();
        test_hold();
        test_bubble();
        test_alu_and_reset_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Latches the execute-to-memory bus, load-type flags and byte-lane select through a stall-aware pipeline register.
- Captures the 1-cycle-latency data SRAM read response and holds it across stalls, then aligns and extends load data (lb/lbu/lh/lhu/lw).
- Produces the write-back bus and the memory-stage forwarding bus for decode.

Parameters:
- EX_TO_MEM_WD, 76, width of incoming execute bus.
- MEM_TO_WB_WD, 70, width of outgoing write-back bus.
- MEM_TO_RF_WD, 38, width of forwarding bus.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- stall  in  6  pipeline stall vector; bit 3 = this stage, bit 4 = write-back; 1 = Stop.
- ex_to_mem_bus  in  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- ex_load_bus  in  5  {inst_lb, inst_lbu, inst_lh, inst_lhu, inst_lw}.
- data_ram_sel  in  4  byte-lane select from execute.
- data_sram_rdata  in  32  SRAM read data, valid one cycle after execute issues the request.
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_rf_bus  out  38  {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}, forwarding to decode.

Behaviour:
- Pipeline register (bus_r, load_r, sel_r) on posedge, priority order:
  - rst: clear all to 0.
  - stall[3]=1 and stall[4]=0: insert bubble, all 0.
  - stall[3]=0: load inputs.
  - otherwise: hold.
- first_r: 1-bit flag.
  - Set to 1 on any edge that loads the register (stall[3]=0 and not rst).
  - Cleared to 0 on every other edge, including bubble and reset.
- rdata_hold_r: 32-bit register.
  - Captures data_sram_rdata on the edge ending a cycle where first_r=1.
  - Otherwise holds. Reset value 0.
- rdata_eff = first_r ? data_sram_rdata : rdata_hold_r.
  - Guarantees the instruction sees its own SRAM response even when held in this stage for N≥1 extra cycles while the SRAM output changes.
- Load alignment from rdata_eff using sel_r:
  - lb/lbu byte lane: sel 0001→[7:0], 0010→[15:8], 0100→[23:16], 1000→[31:24].
  - lh/lhu half lane: sel 0011→[15:0], 1100→[31:16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes rdata_eff.
  - No load flag set, or sel value not listed: load_data=0.
- Write-back data and flags:
  - rf_wdata = sel_rf_res ? load_data : ex_result.
  - rf_we and rf_waddr pass through from the register.
  - Bubble yields rf_we=0, so forwarding is inert.
- Outputs are combinational from registered state plus data_sram_rdata; no extra latency beyond the one register stage.
- Reset values: all outputs 0 during the cycle after rst, since the register is cleared and first_r=0 forces rdata_eff=hold=0.
- Reset mid-hold: the held instruction is discarded and the hold buffer cleared.
- Store instructions: sel_rf_res=0 and rf_we=0; nothing else is required of this stage.
- No handshake outward; stall requests are not generated by this stage.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with random inputs -> mem_to_wb_bus=0 and mem_to_rf_bus=0 in the cycle after rst deasserts.
2. lw, no stall:
   - Stimulus: ex_result=0x1000, rf_waddr=5, sel=1111, sel_rf_res=1, rdata=0xDEADBEEF next cycle.
   - Response: rf_wdata=0xDEADBEEF, rf_we=1, waddr=5.
3. lb/lbu lane 2 with rdata=0x0080FF00:
   - lb sel=0100 -> 0xFFFFFF80.
   - lbu sel=0100 -> 0x00000080.
   - lh sel=1100 -> 0x00000080.
   - lhu sel=0011 -> 0x0000FF00.
4. Hold across stall:
   - Stimulus: lw latched, rdata=0x12345678 in first cycle; stall[3]=stall[4]=1 for 3 cycles while rdata changes to 0xAAAAAAAA.
   - Response: rf_wdata stays 0x12345678 throughout.
5. Bubble: stall[3]=1, stall[4]=0 at an edge -> next cycle rf_we=0, pc=0, rf_wdata=0.
6. ALU result path and reset mid-hold:
   - ALU path: sel_rf_res=0, ex_result=0x00000042 -> rf_wdata=0x42 regardless of rdata.
   - Reset mid-hold: assert rst during a held load -> outputs 0 next cycle.
